// File: rtl/mux_pkg.sv
// Shared constants and elaboration helpers for the arb_mux_n family.
// Mode encodings, channel-index width and parameter sanity check.
package mux_pkg;

    localparam int MODE_FIXED = 0;
    localparam int MODE_RR    = 1;
    localparam int MODE_SEL   = 2;

    function automatic int sel_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic bit params_ok(input int n, input int mode);
        return (n >= 2) && (mode >= MODE_FIXED) && (mode <= MODE_SEL);
    endfunction

endpackage

// File: rtl/rr_grant.sv
// Combinational rotating-priority picker: first request at or after ptr.
// Emits a one-hot grant and its encoded index.
module rr_grant
    import mux_pkg::*;
#(
    parameter int N = 4,
    localparam int SEL_W = sel_width(N)
) (
    input  logic [N-1:0]     req,
    input  logic [SEL_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [SEL_W-1:0] idx
);

    logic             found;
    logic [SEL_W:0]   pos;
    logic [SEL_W-1:0] j;

    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        pos   = '0;
        j     = '0;
        for (int k = 0; k < N; k++) begin
            pos = {1'b0, ptr} + (SEL_W+1)'(k);
            if (pos >= (SEL_W+1)'(N)) begin
                pos = pos - (SEL_W+1)'(N);
            end
            j = pos[SEL_W-1:0];
            if (!found && req[j]) begin
                found  = 1'b1;
                gnt[j] = 1'b1;
                idx    = j;
            end
        end
    end

endmodule

// File: rtl/arb_mux_n.sv
// N-input arbitrated mux with a one-entry registered output stage.
// Policy is fixed priority, round-robin or explicit select by MODE.
module arb_mux_n
    import mux_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int N     = 4,
    parameter int MODE  = MODE_RR,
    localparam int SEL_W = sel_width(N)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N-1:0]       in_valid,
    input  logic [N*WIDTH-1:0] in_data,
    output logic [N-1:0]       in_ready,
    input  logic [SEL_W-1:0]   sel,
    output logic               out_valid,
    output logic [WIDTH-1:0]   out_data,
    output logic [SEL_W-1:0]   out_src,
    input  logic               out_ready
);

    if (!params_ok(N, MODE)) begin : g_bad_params
        $error("arb_mux_n: N must be >= 2 and MODE in 0..2");
    end

    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   out_data_q, out_data_d;
    logic [SEL_W-1:0]   out_src_q, out_src_d;
    logic [SEL_W-1:0]   ptr_q, ptr_d;

    logic [N-1:0]       sel_oh;
    logic [N-1:0]       req;
    logic [N-1:0]       gnt;
    logic [SEL_W-1:0]   gidx;
    logic [SEL_W-1:0]   gptr;
    logic [WIDTH-1:0]   win;
    logic               load;
    logic               xfer;
    logic               unused_sink;

    // An out-of-range sel decodes to all zeros, so it can never grant.
    always_comb begin
        sel_oh = '0;
        for (int i = 0; i < N; i++) begin
            sel_oh[i] = (sel == SEL_W'(i));
        end
    end

    assign req  = (MODE == MODE_SEL) ? (in_valid & sel_oh) : in_valid;
    assign gptr = (MODE == MODE_RR) ? ptr_q : '0;
    assign unused_sink = ^{sel, ptr_q};

    rr_grant #(
        .N (N)
    ) u_grant (
        .req (req),
        .ptr (gptr),
        .gnt (gnt),
        .idx (gidx)
    );

    assign load     = !out_valid_q || out_ready;
    assign xfer     = load && rst_n && (|gnt);
    assign in_ready = (load && rst_n) ? gnt : '0;

    always_comb begin
        win = '0;
        for (int i = 0; i < N; i++) begin
            if (gnt[i]) begin
                win = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_src_d   = out_src_q;
        ptr_d       = ptr_q;
        if (load) begin
            out_valid_d = 1'b0;
        end
        if (xfer) begin
            out_valid_d = 1'b1;
            out_data_d  = win;
            out_src_d   = gidx;
            ptr_d       = (gidx == SEL_W'(N-1)) ? '0 : gidx + SEL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_src_q   <= '0;
            ptr_q       <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_src_q   <= out_src_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_src   = out_src_q;

endmodule

// File: tb/tb_arb_mux_n.sv
// Bench for arb_mux_n: round-robin, fixed and select instances.
// Directed checks plus a queue scoreboard driven by a grant model.
module tb_arb_mux_n;

    bit clk;
    logic rst_n;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    logic [3:0]  a_iv, a_ir;
    logic [31:0] a_id;
    logic [1:0]  a_sel, a_os;
    logic        a_ov, a_or;
    logic [7:0]  a_od;

    logic [3:0]  f_iv, f_ir;
    logic [31:0] f_id;
    logic [1:0]  f_sel, f_os;
    logic        f_ov, f_or;
    logic [7:0]  f_od;

    logic [2:0]  s_iv, s_ir;
    logic [23:0] s_id;
    logic [1:0]  s_sel, s_os;
    logic        s_ov, s_or;
    logic [7:0]  s_od;

    arb_mux_n #(.WIDTH(8), .N(4), .MODE(1)) u_rr (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
        .sel(a_sel), .out_valid(a_ov), .out_data(a_od),
        .out_src(a_os), .out_ready(a_or)
    );

    arb_mux_n #(.WIDTH(8), .N(4), .MODE(0)) u_fx (
        .clk(clk), .rst_n(rst_n),
        .in_valid(f_iv), .in_data(f_id), .in_ready(f_ir),
        .sel(f_sel), .out_valid(f_ov), .out_data(f_od),
        .out_src(f_os), .out_ready(f_or)
    );

    arb_mux_n #(.WIDTH(8), .N(3), .MODE(2)) u_sl (
        .clk(clk), .rst_n(rst_n),
        .in_valid(s_iv), .in_data(s_id), .in_ready(s_ir),
        .sel(s_sel), .out_valid(s_ov), .out_data(s_od),
        .out_src(s_os), .out_ready(s_or)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", nm, act, exp);
        end
    endtask

    logic [15:0] aq[$];
    logic [15:0] fq[$];
    logic [15:0] sq[$];
    int a_ptr = 0;

    // Scoreboard: inputs are stable from here to the next rising edge.
    always @(negedge clk) begin
        int g;
        int j;
        bit ld;
        logic [15:0] e;

        chk("a_valid", 32'(a_ov), 32'(aq.size() != 0));
        chk("f_valid", 32'(f_ov), 32'(fq.size() != 0));
        chk("s_valid", 32'(s_ov), 32'(sq.size() != 0));
        if (!rst_n) begin
            chk("a_rdy_rst", 32'(a_ir), 0);
            chk("f_rdy_rst", 32'(f_ir), 0);
            chk("s_rdy_rst", 32'(s_ir), 0);
            aq.delete();
            fq.delete();
            sq.delete();
            a_ptr = 0;
        end else begin
            // round-robin instance
            ld = (aq.size() == 0) || a_or;
            if (a_or && aq.size() > 0) begin
                e = aq.pop_front();
                chk("a_out", {16'h0, 8'(a_os), a_od}, {16'h0, e});
            end
            g = -1;
            if (ld) begin
                for (int k = 0; k < 4; k++) begin
                    j = (a_ptr + k) % 4;
                    if (g < 0 && a_iv[j]) g = j;
                end
            end
            chk("a_rdy", 32'(a_ir), (g < 0) ? 0 : (1 << g));
            if (g >= 0) begin
                aq.push_back({8'(g), a_id[g*8 +: 8]});
                a_ptr = (g + 1) % 4;
            end

            // fixed-priority instance
            ld = (fq.size() == 0) || f_or;
            if (f_or && fq.size() > 0) begin
                e = fq.pop_front();
                chk("f_out", {16'h0, 8'(f_os), f_od}, {16'h0, e});
            end
            g = -1;
            if (ld) begin
                for (int k = 3; k >= 0; k--) begin
                    if (f_iv[k]) g = k;
                end
            end
            chk("f_rdy", 32'(f_ir), (g < 0) ? 0 : (1 << g));
            if (g >= 0) fq.push_back({8'(g), f_id[g*8 +: 8]});

            // explicit-select instance
            ld = (sq.size() == 0) || s_or;
            if (s_or && sq.size() > 0) begin
                e = sq.pop_front();
                chk("s_out", {16'h0, 8'(s_os), s_od}, {16'h0, e});
            end
            g = -1;
            if (ld && s_sel < 2'd3 && s_iv[s_sel]) g = int'(s_sel);
            chk("s_rdy", 32'(s_ir), (g < 0) ? 0 : (1 << g));
            if (g >= 0) sq.push_back({8'(g), s_id[g*8 +: 8]});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] rr_src[5];
    logic [7:0] rr_dat[5];

    initial begin
        rr_src = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
        rr_dat = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

        rst_n = 0;
        a_iv = 0; a_id = 0; a_sel = 0; a_or = 1;
        f_iv = 0; f_id = 0; f_sel = 0; f_or = 1;
        s_iv = 0; s_id = 0; s_sel = 0; s_or = 1;
        step();
        step();
        rst_n = 1;
        @(negedge clk);
        chk("rst_valid", 32'(a_ov), 0);
        chk("rst_data", 32'(a_od), 0);
        chk("rst_src", 32'(a_os), 0);

        // round-robin over all four channels
        step();
        a_iv = 4'hF;
        a_id = 32'h13121110;
        @(negedge clk);
        chk("rr_first_rdy", 32'(a_ir), 32'b0001);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_src", 32'(a_os), 32'(rr_src[k]));
            chk("rr_data", 32'(a_od), 32'(rr_dat[k]));
        end

        // reset while the output is stalled
        step();
        a_or = 0;
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        a_or = 1;
        @(negedge clk);
        chk("stall_rst_valid", 32'(a_ov), 0);
        chk("stall_rst_data", 32'(a_od), 0);
        chk("stall_rst_src", 32'(a_os), 0);
        @(negedge clk);
        chk("post_rst_valid", 32'(a_ov), 1);
        chk("post_rst_src", 32'(a_os), 0);

        // backpressure hold, then drain and refill on one edge
        step();
        a_iv = 4'b0100;
        a_id = 32'h00AB0000;
        step();
        a_or = 0;
        a_id = 32'h00CD0000;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("bp_data", 32'(a_od), 32'hAB);
            chk("bp_src", 32'(a_os), 2);
            chk("bp_rdy", 32'(a_ir), 0);
        end
        step();
        a_or = 1;
        @(negedge clk);
        chk("bp_release_rdy", 32'(a_ir), 32'b0100);
        @(negedge clk);
        chk("bp_refill_data", 32'(a_od), 32'hCD);
        chk("bp_refill_valid", 32'(a_ov), 1);
        step();
        a_iv = 4'hF;
        a_id = 32'h13121110;
        @(negedge clk);
        chk("rr_after2_rdy", 32'(a_ir), 32'b1000);
        @(negedge clk);
        chk("rr_wrap_src3", 32'(a_os), 3);
        @(negedge clk);
        chk("rr_wrap_src0", 32'(a_os), 0);
        step();
        a_iv = 0;

        // fixed priority: channel 1 starves channel 3
        f_iv = 4'b1010;
        f_id = 32'h23222120;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("fx_rdy", 32'(f_ir), 32'b0010);
        end
        chk("fx_src", 32'(f_os), 1);
        chk("fx_data", 32'(f_od), 32'h21);
        step();
        f_iv = 4'b1000;
        @(negedge clk);
        chk("fx_ch3_rdy", 32'(f_ir), 32'b1000);
        step();
        f_iv = 0;

        // explicit select
        s_iv = 3'b010;
        s_id = 24'h323130;
        s_sel = 2'd1;
        @(negedge clk);
        chk("sel1_rdy", 32'(s_ir), 32'b010);
        step();
        s_sel = 2'd2;
        @(negedge clk);
        chk("sel2_rdy", 32'(s_ir), 0);
        chk("sel1_src", 32'(s_os), 1);
        chk("sel1_data", 32'(s_od), 32'h31);
        @(negedge clk);
        chk("sel2_drop", 32'(s_ov), 0);
        step();
        s_sel = 2'd3;
        s_iv = 3'b111;
        @(negedge clk);
        chk("sel3_rdy", 32'(s_ir), 0);
        @(negedge clk);
        chk("sel3_valid", 32'(s_ov), 0);
        step();
        s_sel = 2'd1;
        @(negedge clk);
        chk("sel1_again", 32'(s_ir), 32'b010);

        // random soak across all three instances
        for (int c = 0; c < 600; c++) begin
            step();
            rst_n = ($urandom_range(0, 63) != 0);
            a_iv = 4'($urandom);
            a_id = $urandom;
            a_or = ($urandom_range(0, 3) != 0);
            f_iv = 4'($urandom);
            f_id = $urandom;
            f_or = ($urandom_range(0, 3) != 0);
            s_iv = 3'($urandom);
            s_id = 24'($urandom);
            s_or = ($urandom_range(0, 3) != 0);
            s_sel = 2'($urandom_range(0, 3));
        end
        step();
        rst_n = 1;
        a_iv = 0; f_iv = 0; s_iv = 0;
        a_or = 1; f_or = 1; s_or = 1;
        repeat (3) @(negedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/arb_mux_n.md
# arb_mux_n

Parametrised N-input, WIDTH-bit multiplexer with a one-entry registered output and a valid/ready handshake on every port. It replaces single-cycle select-line muxes wherever several pipeline producers compete for one consumer, for example writeback sources or next-PC candidates. A mode parameter selects the arbitration policy: fixed priority, round-robin, or an explicit select input. The explicit-select mode preserves the old control-signal behaviour, but registered.

## Interface
- WIDTH, 64: data width per channel; ≥1.
- N, 4: number of input channels; ≥2.
- MODE, 1: arbitration policy. 0 = fixed priority, lowest index wins. 1 = round-robin. 2 = explicit select via `sel`.
- SEL_W, max(1, clog2(N)): width of channel index; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- in_valid  in  N  per-channel request.
- in_data  in  N*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_ready  out  N  per-channel accept; at most one bit high per cycle.
- sel  in  SEL_W  channel index, used only when MODE=2; ignored otherwise.
- out_valid  out  1  output register holds data.
- out_data  out  WIDTH  registered winning data.
- out_src  out  SEL_W  index of the channel that supplied out_data.
- out_ready  in  1  consumer accept.

## Operation
- Transfer on a port occurs when valid and ready are both high at a rising edge.
- Load enable: `load = !out_valid || out_ready`.
  - When load is high, at most one channel is granted and that channel's in_ready is high.
  - When load is low, all in_ready bits are 0.
- Grant rules:
  - MODE 0: lowest-index channel with in_valid=1.
  - MODE 1: first valid channel at or after pointer `ptr`, searching upward and wrapping modulo N. After a transfer from channel g, ptr ← (g+1) mod N. ptr is unchanged on cycles with no transfer.
  - MODE 2: channel `sel` is granted only if in_valid[sel]=1; otherwise no grant. When sel ≥ N, no grant and all in_ready are 0.
- Output register update:
  - On a grant: out_data ← winner data, out_src ← winner index, out_valid ← 1.
  - If load is high and there is no grant: out_valid ← 0. out_data and out_src hold their last values.
- While out_valid=1 and out_ready=0, out_data and out_src are stable.
- The grant must not depend on out_ready except through load. in_ready may depend combinationally on in_valid, sel and out_ready.
- No data is duplicated or dropped. Every accepted input appears on the output exactly once, in acceptance order.

## Timing
- Reset, when rst_n=0 at an edge, forces out_valid=0, out_data=0, out_src=0 and ptr=0. This applies mid-transfer too: the held word is discarded.
- in_ready is 0 during any cycle in which rst_n=0.
- Latency is 1 cycle: data accepted at edge k is on out_data with out_valid=1 after edge k.
- Throughput is one word per cycle while out_ready stays high. Simultaneous drain and refill happen in the same edge.
- Round-robin fairness: with all N channels continuously valid and out_ready=1, the grants follow the sequence 0,1,…,N-1,0,…
- Wrap-around: ptr=N-1 and channel N-1 is granted → ptr becomes 0.
- A backpressure stall does not advance ptr.

## Structure
- Package `mux_pkg` holds:
  - MODE_FIXED=0, MODE_RR=1, MODE_SEL=2 constants.
  - the `sel_width(N)` function.
  - a shared compile-time check that N≥2 and MODE≤2.
- Sub-module `rr_grant`: combinational. Inputs are a req vector and ptr. Outputs are a one-hot grant and the encoded index. In MODE 0 it is instantiated with ptr tied to 0.
- The top level holds the output register, ptr and the load/ready logic.

## Test plan
- Reset mid-stall:
  - Stimulus: out_valid=1, out_ready=0; assert rst_n=0 for one cycle.
  - Response: next cycle out_valid=0, out_data=0, out_src=0. After release, the first grant (MODE 1, all valid) is channel 0.
- Round-robin:
  - Stimulus: N=4, WIDTH=8, all valid, in_data = i+0x10 for channel i, out_ready=1.
  - Response: out_src sequence 0,1,2,3,0; out_data 0x10,0x11,0x12,0x13,0x10.
- Backpressure:
  - Stimulus: out_ready=0 for 3 cycles with channel 2 valid (0xAB).
  - Response: out_data=0xAB and out_src=2 held; in_ready=0 during the stall.
  - Stimulus: out_ready=1.
  - Response: next word loads the same edge.
- Fixed priority (MODE 0):
  - Stimulus: channels 1 and 3 valid.
  - Response: channel 1 wins repeatedly; channel 3 is never granted while channel 1 stays valid.
- Explicit select (MODE 2):
  - Stimulus: sel=2 with in_valid=4'b0010.
  - Response: no grant, out_valid→0.
  - Stimulus: sel=1.
  - Response: channel 1 is granted.
  - Stimulus: sel=3 on N=3.
  - Response: no grant.
- Random soak, all modes: a scoreboard checks exactly-once, in-order delivery and the at-most-one in_ready invariant.
